// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch sequencer. It owns the program counter, addresses a
// synchronous-read instruction memory, splits each word into opcode/literal and
// presents one instruction at a time to decode over a valid/ready handshake.
//
// Ports:
//   clk          system clock (rising edge)
//   reset        synchronous, active-high reset
//   run_en       level, 1 = fetching enabled
//   im_addr      instruction-memory read address (lookahead, see below)
//   im_rdata     instruction-memory read data, one cycle after im_addr
//   opcode       opcode field [14:8] of the presented instruction
//   literal      literal field [7:0] of the presented instruction
//   instr_valid  opcode/literal/pc hold a valid instruction
//   instr_ready  decode accepts the presented instruction this cycle
//   jump_en      load the fetch pointer from jump_addr
//   jump_addr    jump target
//   pc           address of the presented instruction
//   halted       halt-opcode latch status (0 unless FETCH_HALT_OPCODE_EN)
//
// Build option: define FETCH_HALT_OPCODE_EN to make a handshaken all-ones
// opcode park the unit in a sticky HALT state (cleared only by reset).
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int unsigned PC_WIDTH    = 7,
   parameter int unsigned INSTR_WIDTH = 15,
   parameter int unsigned OPC_WIDTH   = 7,
   parameter int unsigned LIT_WIDTH   = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run_en,
   output logic [PC_WIDTH-1:0]    im_addr,
   input  logic [INSTR_WIDTH-1:0] im_rdata,
   output logic [OPC_WIDTH-1:0]   opcode,
   output logic [LIT_WIDTH-1:0]   literal,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   input  logic                   jump_en,
   input  logic [PC_WIDTH-1:0]    jump_addr,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   halted
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] ISSUE = 2'd2;
`ifdef FETCH_HALT_OPCODE_EN
   localparam logic [1:0] HALT  = 2'd3;
`endif

   logic [1:0]           state,       stateNext;
   logic [PC_WIDTH-1:0]  fetchPtr,    fetchPtrNext;
   logic [PC_WIDTH-1:0]  pcReg,       pcNext;
   logic [OPC_WIDTH-1:0] opcodeReg,   opcodeNext;
   logic [LIT_WIDTH-1:0] literalReg,  literalNext;
   logic                 validReg,    validNext;
   logic                 handshake;

   assign handshake = validReg & instr_ready;

`ifdef FETCH_HALT_OPCODE_EN
   logic haltedReg, haltedNext;
   logic haltOpc;
   assign haltOpc = (opcodeReg == {OPC_WIDTH{1'b1}});
`endif

   // Next-state and next-output logic
   always_comb begin
      stateNext    = state;
      fetchPtrNext = fetchPtr;
      pcNext       = pcReg;
      opcodeNext   = opcodeReg;
      literalNext  = literalReg;
      validNext    = validReg;
`ifdef FETCH_HALT_OPCODE_EN
      haltedNext   = haltedReg;
`endif
      case (state)
         IDLE: begin
            validNext = 1'b0;
            if (jump_en) begin
               fetchPtrNext = jump_addr;
            end else if (run_en) begin
               stateNext = REQ;
            end
         end
         REQ: begin
            if (jump_en) begin
               // Abandon the word in flight and refetch from the target.
               fetchPtrNext = jump_addr;
               stateNext    = run_en ? REQ : IDLE;
            end else begin
               opcodeNext  = im_rdata[INSTR_WIDTH-1 -: OPC_WIDTH];
               literalNext = im_rdata[LIT_WIDTH-1:0];
               pcNext      = fetchPtr;
               validNext   = 1'b1;
               stateNext   = ISSUE;
            end
         end
         ISSUE: begin
`ifdef FETCH_HALT_OPCODE_EN
            if (handshake && haltOpc) begin
               haltedNext = 1'b1;
               validNext  = 1'b0;
               stateNext  = HALT;
            end else
`endif
            if (jump_en || handshake) begin
               // A jump wins over pc+1 even when the instruction is consumed.
               fetchPtrNext = jump_en ? jump_addr : PC_WIDTH'(pcReg + 1'b1);
               validNext    = 1'b0;
               stateNext    = run_en ? REQ : IDLE;
            end
         end
`ifdef FETCH_HALT_OPCODE_EN
         HALT: begin
            validNext = 1'b0;
         end
`endif
         default: begin
            validNext = 1'b0;
            stateNext = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         fetchPtr   <= '0;
         pcReg      <= '0;
         opcodeReg  <= '0;
         literalReg <= '0;
         validReg   <= 1'b0;
`ifdef FETCH_HALT_OPCODE_EN
         haltedReg  <= 1'b0;
`endif
      end else begin
         state      <= stateNext;
         fetchPtr   <= fetchPtrNext;
         pcReg      <= pcNext;
         opcodeReg  <= opcodeNext;
         literalReg <= literalNext;
         validReg   <= validNext;
`ifdef FETCH_HALT_OPCODE_EN
         haltedReg  <= haltedNext;
`endif
      end
   end

   // The memory registers its address, so it is given the pointer value the
   // next cycle will fetch from; the word then arrives during REQ.
   assign im_addr     = reset ? '0 : fetchPtrNext;
   assign opcode      = opcodeReg;
   assign literal     = literalReg;
   assign pc          = pcReg;
   assign instr_valid = validReg;
`ifdef FETCH_HALT_OPCODE_EN
   assign halted      = haltedReg;
`else
   assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Bench for instr_fetch_unit: directed vector table, hand-written halt-opcode
// sequence, then randomized traffic against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        run_en;
   logic [6:0]  im_addr;
   logic [14:0] im_rdata;
   logic [6:0]  opcode;
   logic [7:0]  literal;
   logic        instr_valid;
   logic        instr_ready;
   logic        jump_en;
   logic [6:0]  jump_addr;
   logic [6:0]  pc;
   logic        halted;

   int checks = 0;
   int errors = 0;

   logic [14:0] mem [128];

   always #5 clk = ~clk;

   // Synchronous-read instruction memory
   always @(posedge clk) im_rdata <= mem[im_addr];

   instr_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .run_en      (run_en),
      .im_addr     (im_addr),
      .im_rdata    (im_rdata),
      .opcode      (opcode),
      .literal     (literal),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .pc          (pc),
      .halted      (halted)
   );

`ifdef FETCH_HALT_OPCODE_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, return at the next one.
   task automatic step(input logic rst, input logic run, input logic rdy,
                       input logic jmp, input logic [6:0] ja);
      reset = rst; run_en = run; instr_ready = rdy; jump_en = jmp; jump_addr = ja;
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- transaction-level reference model ----------------
   bit          mValid, mBusy, mHalt;
   int          mPc, mPtr;
   logic [14:0] mWord;

   task automatic modelStep(input logic rst, input logic run, input logic rdy,
                            input logic jmp, input logic [6:0] ja);
      if (rst) begin
         mValid = 0; mBusy = 0; mHalt = 0; mPc = 0; mPtr = 0; mWord = '0;
      end else if (mHalt) begin
         // parked until reset
      end else if (mValid) begin
         if (rdy && HALT_EN && mWord[14:8] == 7'h7F) begin
            mHalt = 1; mValid = 0;
         end else if (jmp) begin
            mPtr = int'(ja); mValid = 0; mBusy = run;
         end else if (rdy) begin
            mPtr = (mPc + 1) % 128; mValid = 0; mBusy = run;
         end
      end else if (mBusy) begin
         if (jmp) begin
            mPtr = int'(ja); mBusy = run;
         end else begin
            mValid = 1; mPc = mPtr; mWord = mem[mPtr]; mBusy = 0;
         end
      end else begin
         if (jmp) mPtr = int'(ja);
         else     mBusy = run;
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       rst, run, rdy, jmp;
      logic [6:0] ja;
      logic       eValid;
      logic [6:0] ePc;
   } vec_t;

   localparam int NV = 30;
   vec_t tv [NV];

   initial begin
      logic [14:0] w;
      for (int i = 0; i < 128; i++) mem[i] = {1'b0, 6'(i), 8'(i * 5 + 3)};
      mem[0] = 15'h0205;
      reset = 1'b1; run_en = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;

      //          rst run rdy jmp ja     v  pc
      tv[0]  = '{1'b1,1'b0,1'b0,1'b0,7'h00,1'b0,7'h00};
      tv[1]  = '{1'b0,1'b1,1'b1,1'b0,7'h00,1'b0,7'h00};
      tv[2]  = '{1'b0,1'b1,1'b1,1'b0,7'h00,1'b1,7'h00};
      tv[3]  = '{1'b0,1'b1,1'b1,1'b0,7'h00,1'b0,7'h00};
      tv[4]  = '{1'b0,1'b1,1'b1,1'b0,7'h00,1'b1,7'h01};
      tv[5]  = '{1'b0,1'b1,1'b1,1'b1,7'h40,1'b0,7'h01};
      tv[6]  = '{1'b0,1'b1,1'b1,1'b0,7'h00,1'b1,7'h40};
      tv[7]  = '{1'b0,1'b1,1'b1,1'b0,7'h00,1'b0,7'h40};
      tv[8]  = '{1'b0,1'b1,1'b1,1'b0,7'h00,1'b1,7'h41};
      tv[9]  = '{1'b0,1'b1,1'b0,1'b1,7'h02,1'b0,7'h41};
      tv[10] = '{1'b0,1'b1,1'b0,1'b0,7'h00,1'b1,7'h02};
      for (int i = 11; i < 16; i++)
         tv[i] = '{1'b0,1'b1,1'b0,1'b0,7'h00,1'b1,7'h02};
      tv[16] = '{1'b0,1'b1,1'b1,1'b0,7'h00,1'b0,7'h02};
      tv[17] = '{1'b0,1'b1,1'b1,1'b0,7'h00,1'b1,7'h03};
      tv[18] = '{1'b0,1'b0,1'b0,1'b0,7'h00,1'b1,7'h03};
      tv[19] = '{1'b0,1'b0,1'b1,1'b0,7'h00,1'b0,7'h03};
      tv[20] = '{1'b0,1'b0,1'b0,1'b1,7'h7F,1'b0,7'h03};
      tv[21] = '{1'b0,1'b1,1'b0,1'b0,7'h00,1'b0,7'h03};
      tv[22] = '{1'b0,1'b1,1'b1,1'b0,7'h00,1'b1,7'h7F};
      tv[23] = '{1'b0,1'b1,1'b1,1'b0,7'h00,1'b0,7'h7F};
      tv[24] = '{1'b0,1'b1,1'b0,1'b0,7'h00,1'b1,7'h00};
      tv[25] = '{1'b1,1'b1,1'b0,1'b0,7'h00,1'b0,7'h00};
      tv[26] = '{1'b0,1'b0,1'b0,1'b0,7'h00,1'b0,7'h00};
      tv[27] = '{1'b0,1'b1,1'b0,1'b0,7'h00,1'b0,7'h00};
      tv[28] = '{1'b0,1'b0,1'b0,1'b0,7'h00,1'b1,7'h00};
      tv[29] = '{1'b0,1'b0,1'b1,1'b0,7'h00,1'b0,7'h00};

      @(negedge clk);
      step(1'b1, 1'b0, 1'b0, 1'b0, 7'h00);
      chk("reset_valid",   32'(instr_valid), 32'd0);
      chk("reset_pc",      32'(pc),          32'd0);
      chk("reset_opcode",  32'(opcode),      32'd0);
      chk("reset_literal", 32'(literal),     32'd0);
      chk("reset_halted",  32'(halted),      32'd0);
      chk("reset_im_addr", 32'(im_addr),     32'd0);

      for (int i = 0; i < NV; i++) begin
         step(tv[i].rst, tv[i].run, tv[i].rdy, tv[i].jmp, tv[i].ja);
         chk($sformatf("tv%0d_valid", i), 32'(instr_valid), 32'(tv[i].eValid));
         chk($sformatf("tv%0d_pc", i),    32'(pc),          32'(tv[i].ePc));
         chk($sformatf("tv%0d_halted", i), 32'(halted),     32'd0);
         if (tv[i].eValid) begin
            w = mem[tv[i].ePc];
            chk($sformatf("tv%0d_opcode", i),  32'(opcode),  32'(w[14:8]));
            chk($sformatf("tv%0d_literal", i), 32'(literal), 32'(w[7:0]));
         end
      end

      // ---------------- halt-opcode sequence ----------------
      mem[1] = 15'h7F00;
      mem[2] = 15'h1234;
      step(1'b1, 1'b0, 1'b0, 1'b0, 7'h00);
      step(1'b0, 1'b1, 1'b1, 1'b0, 7'h00);
      step(1'b0, 1'b1, 1'b1, 1'b0, 7'h00);
      step(1'b0, 1'b1, 1'b1, 1'b0, 7'h00);
      step(1'b0, 1'b1, 1'b1, 1'b0, 7'h00);
      chk("halt_op_valid",  32'(instr_valid), 32'd1);
      chk("halt_op_pc",     32'(pc),          32'd1);
      chk("halt_op_opcode", 32'(opcode),      32'h7F);
      step(1'b0, 1'b1, 1'b1, 1'b0, 7'h00);
`ifdef FETCH_HALT_OPCODE_EN
      chk("halt_set",     32'(halted),      32'd1);
      chk("halt_novalid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b1, i[0], 7'h10);
         chk("halt_sticky",  32'(halted),      32'd1);
         chk("halt_idle",    32'(instr_valid), 32'd0);
      end
`else
      chk("nohalt_flag", 32'(halted), 32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 7'h00);
      chk("nohalt_valid",   32'(instr_valid), 32'd1);
      chk("nohalt_pc",      32'(pc),          32'd2);
      chk("nohalt_opcode",  32'(opcode),      32'h12);
      chk("nohalt_literal", 32'(literal),     32'h34);
`endif

      // ---------------- randomized traffic vs model ----------------
      for (int i = 0; i < 128; i++) mem[i] = 15'($urandom) & 15'h3FFF;
      step(1'b1, 1'b0, 1'b0, 1'b0, 7'h00);
      modelStep(1'b1, 1'b0, 1'b0, 1'b0, 7'h00);
      for (int n = 0; n < 3000; n++) begin
         logic       rR, rRun, rRdy, rJmp;
         logic [6:0] rJa;
         rR   = ($urandom_range(0, 199) == 0);
         rRun = ($urandom_range(0, 9) < 8);
         rRdy = ($urandom_range(0, 9) < 6);
         rJmp = ($urandom_range(0, 9) == 0);
         rJa  = 7'($urandom);
         reset = rR; run_en = rRun; instr_ready = rRdy; jump_en = rJmp; jump_addr = rJa;
         @(posedge clk);
         modelStep(rR, rRun, rRdy, rJmp, rJa);
         @(negedge clk);
         chk("rnd_valid",  32'(instr_valid), 32'(mValid));
         chk("rnd_halted", 32'(halted),      32'(mHalt));
         if (mValid) begin
            chk("rnd_pc",      32'(pc),      32'(mPc));
            chk("rnd_opcode",  32'(opcode),  32'(mWord[14:8]));
            chk("rnd_literal", 32'(literal), 32'(mWord[7:0]));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
